// File: rtl/edge_request_scheduler.sv
// Shares one decryption engine among N asynchronous request sources.
// Requests are synchronised, edge-trapped, granted round-robin, and the engine run is guarded by a watchdog.
module edge_request_scheduler #(
    parameter int N_REQ       = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             restart,
    input  logic [N_REQ-1:0] async_req,
    output logic             eng_start,
    input  logic             eng_done,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic [N_REQ-1:0] req_ack,
    output logic [N_REQ-1:0] pending,
    output logic             timeout_err
);

    localparam int unsigned NR = N_REQ;
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_ACK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N_REQ-1:0] s1;
    logic [N_REQ-1:0] s2;
    logic [N_REQ-1:0] prev;
    logic [N_REQ-1:0] edges;
    logic [N_REQ-1:0] grant_mask;
    logic [N_REQ-1:0] clear_mask;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             set_timeout;
    logic [WDW-1:0]   watchdog;

    // Chain resets high so a line already held high at release is not taken as a new edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1   <= '1;
            s2   <= '1;
            prev <= '1;
        end else begin
            s1   <= async_req;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign edges      = s2 & ~prev;
    assign grant_mask = N_REQ'(1) << grant_id;
    assign clear_mask = (state == S_ACK) ? grant_mask : '0;

    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = IDW'((32'(rr_ptr) + i) % NR);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else if (restart) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        eng_start   = 1'b0;
        grant_valid = 1'b0;
        req_ack     = '0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) state_next = S_ARB;
            end
            S_ARB: begin
                state_next = S_START;
            end
            S_START: begin
                eng_start   = 1'b1;
                grant_valid = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                grant_valid = 1'b1;
                if (eng_done) begin
                    state_next = S_ACK;
                end else if (TIMEOUT_CYC != 0 && watchdog == WD_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_ACK;
                end
            end
            S_ACK: begin
                req_ack     = grant_mask;
                grant_valid = 1'b1;
                state_next  = (|(pending & ~grant_mask)) ? S_ARB : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pending     <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else if (restart) begin
            pending     <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Set beats clear when a new edge lands in the ACK cycle of the same source.
            pending <= (pending & ~clear_mask) | edges;
            if (state == S_ARB) begin
                grant_id <= winner;
                rr_ptr   <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state == S_START) begin
                watchdog <= '0;
            end else if (state == S_WAIT && watchdog != '1) begin
                watchdog <= watchdog + 1'b1;
            end
            if (set_timeout) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_request_scheduler.sv
// Scenario bench for edge_request_scheduler: directed cases plus randomized request sets
// checked against a round-robin model held as a plain array and pointer.
module tb_edge_request_scheduler;

    logic       clk = 1'b0;
    logic       clr;
    logic       restart;
    logic [3:0] async_req;
    logic       eng_start;
    logic       eng_done;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] req_ack;
    logic [3:0] pending;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    bit model_pend[4];
    int model_rr;

    always #5 clk = ~clk;

    edge_request_scheduler #(
        .N_REQ(4),
        .IDW(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .clr(clr),
        .restart(restart),
        .async_req(async_req),
        .eng_start(eng_start),
        .eng_done(eng_done),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .req_ack(req_ack),
        .pending(pending),
        .timeout_err(timeout_err)
    );

    function automatic int model_pick();
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (model_rr + k) % 4;
            if (model_pend[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit model_any();
        return model_pend[0] | model_pend[1] | model_pend[2] | model_pend[3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        async_req = '0;
        eng_done  = 1'b0;
        restart   = 1'b0;
        clr       = 1'b1;
        repeat (3) tick();
        clr = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) model_pend[k] = 1'b0;
        model_rr = 0;
    endtask

    task automatic wait_start(input int max, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n <= max) begin
            if (eng_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    // Called while START is observed; returns the req_ack seen in the ACK cycle.
    task automatic finish_run(input int delay, output logic [3:0] ack, output int extra);
        extra = 0;
        tick();
        repeat (delay) begin
            if (eng_start === 1'b1) extra++;
            tick();
        end
        if (eng_start === 1'b1) extra++;
        eng_done = 1'b1;
        tick();
        ack      = req_ack;
        eng_done = 1'b0;
    endtask

    task automatic test_reset();
        async_req = '0;
        eng_done  = 1'b0;
        restart   = 1'b0;
        clr       = 1'b1;
        tick();
        tests++;
        if ({eng_start, grant_valid, grant_id, req_ack, pending, timeout_err} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {eng_start, grant_valid, grant_id, req_ack, pending, timeout_err});
        end
        clr = 1'b0;
        repeat (4) tick();
        tests++;
        if ({eng_start, grant_valid, pending} !== 6'd0) begin
            fails++;
            $display("FAIL reset_idle: got %b required 0", {eng_start, grant_valid, pending});
        end
    endtask

    task automatic test_single();
        do_reset();
        async_req[2] = 1'b1;
        tick();
        tick();
        tests++;
        if (pending !== 4'b0000) begin
            fails++;
            $display("FAIL single_pend_early: got %b required 0000", pending);
        end
        tick();
        tests++;
        if (pending !== 4'b0100) begin
            fails++;
            $display("FAIL single_pend_set: got %b required 0100", pending);
        end
        tick();
        tick();
        tests++;
        if ({eng_start, grant_valid, grant_id} !== 4'b1110) begin
            fails++;
            $display("FAIL single_start: got start=%b valid=%b id=%0d required 1 1 2", eng_start, grant_valid, grant_id);
        end
        repeat (10) tick();
        eng_done = 1'b1;
        tick();
        tests++;
        if (req_ack !== 4'b0100) begin
            fails++;
            $display("FAIL single_ack: got %b required 0100", req_ack);
        end
        eng_done  = 1'b0;
        async_req = '0;
        tick();
        tests++;
        if ({pending, grant_valid, req_ack} !== 9'd0) begin
            fails++;
            $display("FAIL single_after_ack: got pend=%b valid=%b ack=%b required 0", pending, grant_valid, req_ack);
        end
    endtask

    task automatic test_fairness();
        int         order1[4] = '{0, 1, 2, 3};
        int         order2[2] = '{0, 3};
        int         n;
        int         extra;
        bit         seen;
        logic [3:0] ack;
        logic [1:0] e2;
        do_reset();
        async_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_start(12, n, seen);
            async_req = '0;
            e2 = 2'(order1[k]);
            tests++;
            if (!seen || grant_id !== e2 || (k > 0 && n != 2)) begin
                fails++;
                $display("FAIL fair_grant%0d: got seen=%0d id=%0d lat=%0d required id=%0d lat=2", k, seen, grant_id, n, e2);
            end
            finish_run(k + 1, ack, extra);
            tests++;
            if (ack !== (4'b0001 << order1[k]) || extra != 0) begin
                fails++;
                $display("FAIL fair_ack%0d: got %b extra=%0d required %b", k, ack, extra, 4'b0001 << order1[k]);
            end
        end
        repeat (3) tick();
        async_req = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            wait_start(12, n, seen);
            async_req = '0;
            e2 = 2'(order2[k]);
            tests++;
            if (!seen || grant_id !== e2) begin
                fails++;
                $display("FAIL fair2_grant%0d: got seen=%0d id=%0d required %0d", k, seen, grant_id, e2);
            end
            finish_run(3, ack, extra);
            tests++;
            if (ack !== (4'b0001 << order2[k])) begin
                fails++;
                $display("FAIL fair2_ack%0d: got %b required %b", k, ack, 4'b0001 << order2[k]);
            end
        end
    endtask

    task automatic test_merge();
        int         n;
        int         extra;
        int         starts;
        bit         seen;
        logic [3:0] ack;
        do_reset();
        async_req = 4'b0010;
        wait_start(10, n, seen);
        async_req = '0;
        tick();
        repeat (3) tick();
        async_req[1] = 1'b1;
        tick();
        eng_done = 1'b1;
        tick();
        tests++;
        if (req_ack !== 4'b0010) begin
            fails++;
            $display("FAIL merge_ack1: got %b required 0010", req_ack);
        end
        eng_done = 1'b0;
        tick();
        tests++;
        if (pending !== 4'b0010) begin
            fails++;
            $display("FAIL merge_pend_kept: got %b required 0010", pending);
        end
        wait_start(10, n, seen);
        async_req = '0;
        tests++;
        if (!seen || grant_id !== 2'd1) begin
            fails++;
            $display("FAIL merge_regrant: got seen=%0d id=%0d required 1", seen, grant_id);
        end
        finish_run(4, ack, extra);
        tick();
        tests++;
        if (pending !== 4'b0000) begin
            fails++;
            $display("FAIL merge_pend_clear: got %b required 0000", pending);
        end
        // two edges on source 1 while source 0 owns the engine
        async_req = 4'b0001;
        wait_start(10, n, seen);
        tick();
        async_req = 4'b0010;
        repeat (3) tick();
        async_req = 4'b0000;
        repeat (3) tick();
        async_req = 4'b0010;
        repeat (3) tick();
        tests++;
        if (pending !== 4'b0011) begin
            fails++;
            $display("FAIL merge_pend_two: got %b required 0011", pending);
        end
        eng_done = 1'b1;
        tick();
        eng_done  = 1'b0;
        async_req = '0;
        wait_start(10, n, seen);
        tests++;
        if (!seen || grant_id !== 2'd1) begin
            fails++;
            $display("FAIL merge_grant1: got seen=%0d id=%0d required 1", seen, grant_id);
        end
        finish_run(2, ack, extra);
        starts = 0;
        repeat (20) begin
            tick();
            if (eng_start === 1'b1) starts++;
        end
        tests++;
        if (starts != 0) begin
            fails++;
            $display("FAIL merge_single_grant: got %0d extra starts required 0", starts);
        end
    endtask

    task automatic test_watchdog();
        int n;
        bit seen;
        do_reset();
        async_req = 4'b1000;
        wait_start(10, n, seen);
        async_req = '0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (req_ack !== 4'b0000) break;
        end
        tests++;
        if (n != 17 || req_ack !== 4'b1000 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL wd_abort: got cycles=%0d ack=%b err=%b required 17 1000 1", n, req_ack, timeout_err);
        end
        tick();
        tests++;
        if (timeout_err !== 1'b1 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL wd_sticky: got err=%b valid=%b required 1 0", timeout_err, grant_valid);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL wd_restart_clear: got %b required 0", timeout_err);
        end
        async_req = 4'b1000;
        wait_start(10, n, seen);
        async_req = '0;
        repeat (16) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tests++;
        if (req_ack !== 4'b1000 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL wd_done_wins: got ack=%b err=%b required 1000 0", req_ack, timeout_err);
        end
    endtask

    task automatic test_restart();
        int n;
        int bad;
        bit seen;
        do_reset();
        async_req = 4'b0111;
        wait_start(10, n, seen);
        tick();
        tests++;
        if (pending !== 4'b0111 || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: got pend=%b valid=%b required 0111 1", pending, grant_valid);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tests++;
        if ({grant_valid, pending, req_ack, eng_start} !== 10'd0) begin
            fails++;
            $display("FAIL rst_cleared: got valid=%b pend=%b ack=%b start=%b required 0", grant_valid, pending, req_ack, eng_start);
        end
        eng_done = 1'b1;
        bad = 0;
        repeat (12) begin
            tick();
            if (eng_start !== 1'b0 || req_ack !== 4'b0000 || grant_valid !== 1'b0 || pending !== 4'b0000) bad++;
        end
        eng_done  = 1'b0;
        async_req = '0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rst_quiet: got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_clr_mid();
        int n;
        int bad;
        bit seen;
        do_reset();
        async_req = 4'b0100;
        wait_start(10, n, seen);
        tick();
        tick();
        tests++;
        if (grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL clr_pre: got valid=%b required 1", grant_valid);
        end
        #2;
        clr = 1'b1;
        #1;
        tests++;
        if ({eng_start, grant_valid, grant_id, req_ack, pending, timeout_err} !== 13'd0) begin
            fails++;
            $display("FAIL clr_async: got %b required 0", {eng_start, grant_valid, grant_id, req_ack, pending, timeout_err});
        end
        #2;
        clr = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (eng_start !== 1'b0 || pending !== 4'b0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL clr_no_regrant: got %0d active cycles required 0", bad);
        end
        async_req = '0;
    endtask

    task automatic test_random();
        int         n;
        int         extra;
        int         exp;
        int         delay;
        bit         seen;
        bit         first;
        logic [3:0] mask;
        logic [3:0] ack;
        logic [1:0] e2;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) if (mask[k]) model_pend[k] = 1'b1;
            async_req = mask;
            first = 1'b1;
            wait_start(12, n, seen);
            async_req = '0;
            while (model_any()) begin
                exp = model_pick();
                e2  = 2'(exp);
                tests++;
                if (!seen || grant_id !== e2 || n != (first ? 5 : 2)) begin
                    fails++;
                    $display("FAIL rand_grant r%0d: got seen=%0d id=%0d lat=%0d required id=%0d lat=%0d", r, seen, grant_id, n, e2, first ? 5 : 2);
                end
                first = 1'b0;
                delay = $urandom_range(0, 12);
                finish_run(delay, ack, extra);
                tests++;
                if (ack !== (4'b0001 << exp) || extra != 0) begin
                    fails++;
                    $display("FAIL rand_ack r%0d: got %b extra=%0d required %b", r, ack, extra, 4'b0001 << exp);
                end
                model_pend[exp] = 1'b0;
                model_rr        = (exp + 1) % 4;
                if (model_any()) wait_start(10, n, seen);
            end
            tick();
            tests++;
            if (pending !== 4'b0000 || grant_valid !== 1'b0) begin
                fails++;
                $display("FAIL rand_drain r%0d: got pend=%b valid=%b required 0000 0", r, pending, grant_valid);
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_merge();
        test_watchdog();
        test_restart();
        test_clr_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
